serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder that sits in the same arithmetic path as the HA cell, one stage downstream of it.
- Each cycle it consumes one LSB-first bit pair from internal operand shift registers.
- The bit cell is a full adder built from two HA instances plus an OR; a carry flip-flop closes the loop between bits.
- It accepts parallel operands on a start handshake and returns a parallel sum, carry-out and a done pulse.

Parameters:
- N, 8, operand and sum width in bits (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  N  operand A; captured on accepted start.
- b  input  N  operand B; captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; sum/carry valid from this cycle.
- sum  output  N  result register.
- carry  output  1  carry-out of MSB.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
  - While rst=1 at an edge: state=IDLE; operand regs, bit counter, carry FF, sum, carry, done, busy all cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: load a/b into shift regs, clear carry FF, clear counter, go RUN.
  - start=0: stay in IDLE.
- RUN (exactly N cycles):
  - Each edge: s = a_sr[0]^b_sr[0]^c and c' = majority(a_sr[0], b_sr[0], c).
  - Shift a_sr and b_sr right by 1; shift s into the MSB of the partial-sum reg (right shift); counter++.
  - On the edge where the counter reaches N-1: write the partial-sum reg (including the current bit) to sum, write c' to carry, go DONE.
- DONE (one cycle): done=1, busy=1. The next edge always goes to IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+N. Throughput is one operation per N+2 cycles.
- sum and carry keep the previous result throughout RUN. They change only on the RUN→DONE edge and stay stable until the next completion or reset.
- start while busy=1 (RUN or DONE) is ignored; no queuing. start held high continuously restarts from IDLE, giving back-to-back operations with one IDLE cycle between them.
- a/b changing after acceptance has no effect on the operation in flight.
- Wrap-around: sum is modulo 2^N; overflow is reported only via carry.
- Reset mid-RUN: operation abandoned, all outputs go to 0 on that edge, no done pulse.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with start.
  - sub=1: b is inverted on load and the carry FF is preset to 1, computing a-b mod 2^N. carry=1 means no borrow (a>=b).
  - sub=0: addition, identical to the base block.
- Undefined: no sub port; addition only; logic removed.

Test Plan:
- N=8, rst 2 cycles then start with a=0x35, b=0x4A → done pulse in the 9th cycle after the start edge; sum=0x7F, carry=0; busy high for 9 cycles.
- a=0xFF, b=0x01 → sum=0x00, carry=1. Then a=0x80, b=0x80 → sum=0x00, carry=1. Then a=0x00, b=0x00 → sum=0x00, carry=0.
- Start a=0x12, b=0x34; in RUN pulse start with a=0xFF, b=0xFF → second start ignored; result sum=0x46, carry=0; exactly one done pulse.
- Complete 0x01+0x02 (sum=0x03), then start 0x10+0x20 and assert rst on the 4th RUN cycle → sum=0, carry=0, busy=0 next cycle, no done. A following start 0x0F+0x01 → sum=0x10.
- start held high for 30 cycles with constant a=0x0A, b=0x05 → done pulses every 10 cycles, each with sum=0x0F, carry=0.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 → sum=0x0F, carry=1. sub=1, a=0x01, b=0x02 → sum=0xFF, carry=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: LSB-first full adder (two HA cells + OR) with a carry flip-flop.
// Optional SERIAL_ADDER_SUB_EN adds a sub input for a-b mod 2^N (carry=1 means no borrow).

module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         carry
);
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  ps;
  logic [CW-1:0] cnt;
  logic          c_ff;

  logic          s0, c0, s_bit, c1, c_next;
  logic [N-1:0]  ps_next;
  logic [N-1:0]  b_load;
  logic          c_init;

  // Full-adder bit cell closing the loop through c_ff
  ha u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(s0),    .c(c0));
  ha u_ha1 (.a(s0),      .b(c_ff),    .s(s_bit), .c(c1));
  assign c_next  = c0 | c1;
  assign ps_next = (ps >> 1) | {s_bit, {(N-1){1'b0}}};

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction as a + ~b + 1
  assign b_load = sub ? ~b : b;
  assign c_init = sub;
`else
  assign b_load = b;
  assign c_init = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      ps    <= '0;
      cnt   <= '0;
      c_ff  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            c_ff  <= c_init;
            ps    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          ps   <= ps_next;
          c_ff <= c_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N-1)) begin
            sum   <= ps_next;
            carry <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
